// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmitter state type and the baud divider helper.
// The receive side imports this package as well, so both directions agree on the divider.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Rounded clock cycles per bit.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead byte FIFO for the UART transmitter.
// The head entry is always visible on rd_data_o; rd_en_i pops it.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] wr_data_i,
    input  logic                   wr_en_i,
    input  logic                   rd_en_i,
    output logic [UART_DATA_W-1:0] rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            level_q;
    logic                   do_wr;
    logic                   do_rd;

    // DEPTH is a power of two, so the level MSB is set exactly when full.
    assign full_o    = level_q[AW];
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_wr     = wr_en_i & ~full_o;
    assign do_rd     = rd_en_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_wr && !do_rd) begin
                level_q <= level_q + 1'b1;
            end else if (do_rd && !do_wr) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO on a valid/ready input, LSB-first serialiser on tx_o.
// The line output is registered, so tx_o trails the FSM state by one clock.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 460_800,
    parameter int FIFO_DEPTH  = 16,
    parameter int STOP_BITS   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [UART_DATA_W-1:0]      tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ_HZ, BAUD);
    localparam int CNT_W    = $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       DATA_LAST = 3'(UART_DATA_W - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_DATA  = DATA;
    localparam logic [1:0] S_STOP  = STOP;

    logic [1:0]             state_q,    state_d;
    logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
    logic [2:0]             bit_cnt_q,  bit_cnt_d;
    logic [UART_DATA_W-1:0] shreg_q,    shreg_d;
    logic                   tx_q,       tx_d;

    logic                   baud_tick;
    logic                   fifo_rd;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_rdata;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data_i (tx_data_i),
        .wr_en_i   (tx_valid_i),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level_o)
    );

    assign baud_tick  = (baud_cnt_q == BAUD_LAST);
    assign tx_ready_o = ~fifo_full;
    assign busy_o     = (state_q != S_IDLE) | ~fifo_empty;
    assign tx_o       = tx_q;

    // The end of the last stop bit pops the next byte directly into START, keeping frames contiguous.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        fifo_rd    = 1'b0;
        if (state_q != S_IDLE) begin
            baud_cnt_d = baud_tick ? '0 : baud_cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd    = 1'b1;
                    shreg_d    = fifo_rdata;
                    bit_cnt_d  = '0;
                    baud_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        if (!fifo_empty) begin
                            fifo_rd = 1'b1;
                            shreg_d = fifo_rdata;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: directed sequence plus random bytes, checked against a line-level
// frame model and a sampling receiver; a second instance covers two stop bits.
module tb_uart_tx;

    localparam int CLK_HZ    = 4_608_000;
    localparam int BAUD_RATE = 460_800;
    localparam int DIV       = (CLK_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int DEPTH     = 16;
    localparam int FRAME1    = 10 * DIV;
    localparam int FRAME2    = 11 * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_level;

    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       tx2;
    logic       busy2;
    logic [4:0] fifo_level2;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [7:0] expQ[$];
    logic [7:0] sentQ[$];
    logic [7:0] rxQ[$];
    int         startQ[$];

    uart_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_RATE),
        .FIFO_DEPTH  (DEPTH),
        .STOP_BITS   (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .tx_o         (tx),
        .busy_o       (busy),
        .fifo_level_o (fifo_level)
    );

    uart_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_RATE),
        .FIFO_DEPTH  (DEPTH),
        .STOP_BITS   (2)
    ) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data_i    (tx_data2),
        .tx_valid_i   (tx_valid2),
        .tx_ready_o   (tx_ready2),
        .tx_o         (tx2),
        .busy_o       (busy2),
        .fifo_level_o (fifo_level2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected line level k cycles into a frame: start slot, eight data slots LSB first, then stop.
    function automatic logic lineBit(input logic [7:0] b, input int k);
        int slot = k / DIV;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot - 1];
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Presents one byte and holds it until the handshake completes (or a bound expires).
    task automatic applyStimulus(input logic [7:0] b, output int waited, output int accCyc,
                                 output int levelStart, output int levelAcc);
        waited = 0;
        @(negedge clk);
        tx_data    = b;
        tx_valid   = 1'b1;
        levelStart = int'(fifo_level);
        while (tx_ready !== 1'b1 && waited < 400) begin
            waited++;
            @(negedge clk);
        end
        levelAcc = int'(fifo_level);
        accCyc   = cyc + 1;
        if (tx_ready === 1'b1) begin
            expQ.push_back(b);
            sentQ.push_back(b);
        end else begin
            checkOutput("accept timeout", tx_ready, 1'b1);
        end
    endtask

    task automatic releaseValid();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int limit, output int dropCyc);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < limit) begin
            n++;
            @(negedge clk);
        end
        dropCyc = cyc;
        checkOutput({tag, " idle"}, busy, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    // Receiver on dut's line: checks every cycle of each frame and decodes at mid-bit.
    initial begin : monitor
        logic       prevTx;
        logic [7:0] want;
        logic [7:0] got;
        bit         have;
        bit         aborted;
        int         bad;
        prevTx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prevTx = 1'b1;
            end else if (prevTx === 1'b1 && tx === 1'b0) begin
                startQ.push_back(cyc);
                have = (expQ.size() != 0);
                if (have) want = expQ.pop_front();
                else want = 8'h00;
                bad     = 0;
                got     = '0;
                aborted = 1'b0;
                for (int k = 0; k < FRAME1; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx !== lineBit(want, k)) bad++;
                    if (k / DIV >= 1 && k / DIV <= 8 && k % DIV == DIV / 2) got[k / DIV - 1] = tx;
                end
                if (!aborted) begin
                    checkOutput("frame had queued byte", have, 1'b1);
                    checkOutput("frame bad cycles", bad, 0);
                    rxQ.push_back(got);
                end
                prevTx = tx;
            end else begin
                prevTx = tx;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int         w, acc, l0, l1, drop, bad, busyLow;
        int         accs[18];
        logic [7:0] a, b;
        logic [7:0] hi[3];

        rst_n     = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_valid2 = 1'b0;
        tx_data2  = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("reset tx", tx, 1'b1);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset level", fifo_level, 0);
        checkOutput("reset ready", tx_ready, 1'b1);
        checkOutput("reset tx2", tx2, 1'b1);
        checkOutput("reset level2", fifo_level2, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single byte 0x55");
        sentQ.delete(); rxQ.delete(); startQ.delete();
        applyStimulus(8'h55, w, acc, l0, l1);
        releaseValid();
        waitIdle("t1", 400, drop);
        checkOutput("t1 start latency", (startQ.size() > 0) ? startQ[0] - acc : -1, 2);
        // One cycle to pop, then 100 frame cycles before the FSM is back in IDLE.
        checkOutput("t1 busy drop", drop - acc, 1 + FRAME1);
        checkOutput("t1 rx byte", (rxQ.size() == 1) ? int'(rxQ[0]) : -1, 8'h55);

        $display("[TB] burst H i LF");
        sentQ.delete(); rxQ.delete(); startQ.delete();
        hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;
        for (int i = 0; i < 3; i++) applyStimulus(hi[i], w, acc, l0, l1);
        releaseValid();
        waitIdle("t2", 800, drop);
        checkOutput("t2 rx count", rxQ.size(), 3);
        for (int i = 0; i < 3 && i < rxQ.size(); i++) checkOutput("t2 rx byte", rxQ[i], hi[i]);
        for (int i = 1; i < startQ.size(); i++) checkOutput("t2 frame gap", startQ[i] - startQ[i-1], FRAME1);

        $display("[TB] overfill with random bytes");
        sentQ.delete(); rxQ.delete(); startQ.delete();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(8'($urandom), w, accs[i], l0, l1);
            if (i == 17) begin
                checkOutput("t3 level when full", l0, DEPTH);
                checkOutput("t3 ready held low", (w > 0), 1'b1);
                checkOutput("t3 level at accept", l1, DEPTH - 1);
                checkOutput("t3 accept after pop", accs[17] - accs[0], FRAME1 + 2);
            end
        end
        releaseValid();
        waitIdle("t3", 2500, drop);
        checkOutput("t3 rx count", rxQ.size(), 18);
        bad = 0;
        for (int i = 0; i < rxQ.size() && i < sentQ.size(); i++) if (rxQ[i] !== sentQ[i]) bad++;
        checkOutput("t3 rx order", bad, 0);
        bad = 0;
        for (int i = 1; i < startQ.size(); i++) if (startQ[i] - startQ[i-1] != FRAME1) bad++;
        checkOutput("t3 gaps", bad, 0);

        $display("[TB] reset mid frame");
        sentQ.delete(); rxQ.delete(); startQ.delete();
        applyStimulus(8'hA5, w, acc, l0, l1);
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), w, l0, l0, l1);
        releaseValid();
        while (cyc < acc + 2 + 45) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t4 tx in reset", tx, 1'b1);
        checkOutput("t4 level in reset", fifo_level, 0);
        checkOutput("t4 busy in reset", busy, 1'b0);
        checkOutput("t4 ready in reset", tx_ready, 1'b1);
        expQ.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rxQ.delete(); startQ.delete();
        applyStimulus(8'h3C, w, acc, l0, l1);
        releaseValid();
        waitIdle("t4", 400, drop);
        checkOutput("t4 rx count", rxQ.size(), 1);
        checkOutput("t4 rx byte", (rxQ.size() > 0) ? int'(rxQ[0]) : -1, 8'h3C);

        $display("[TB] all zeros then all ones");
        sentQ.delete(); rxQ.delete(); startQ.delete();
        applyStimulus(8'h00, w, acc, l0, l1);
        applyStimulus(8'hFF, w, acc, l0, l1);
        releaseValid();
        waitIdle("t5", 600, drop);
        checkOutput("t5 rx count", rxQ.size(), 2);
        checkOutput("t5 rx zero", (rxQ.size() > 0) ? int'(rxQ[0]) : -1, 8'h00);
        checkOutput("t5 rx ones", (rxQ.size() > 1) ? int'(rxQ[1]) : -1, 8'hFF);

        $display("[TB] two stop bits, push on final stop cycle");
        a = 8'($urandom);
        b = 8'($urandom);
        @(negedge clk);
        tx_data2  = a;
        tx_valid2 = 1'b1;
        checkOutput("t6 ready2", tx_ready2, 1'b1);
        @(negedge clk);
        tx_valid2 = 1'b0;
        // Now just after the accept edge. A's FSM frame spans edges 1..111; B lands on edge 111,
        // sees one IDLE cycle, and pops at edge 112; the line lags the FSM by one cycle.
        bad     = 0;
        busyLow = -1;
        for (int t = 0; t <= 230; t++) begin
            logic e;
            if (t > 0) @(negedge clk);
            if (t == 110) begin
                tx_data2  = b;
                tx_valid2 = 1'b1;
            end
            if (t == 111) tx_valid2 = 1'b0;
            if (t >= 2 && t < 2 + FRAME2) e = lineBit(a, t - 2);
            else if (t >= 113 && t < 113 + FRAME2) e = lineBit(b, t - 113);
            else e = 1'b1;
            if (tx2 !== e) bad++;
            if (busy2 === 1'b0 && busyLow < 0) busyLow = t;
        end
        checkOutput("t6 line cycles wrong", bad, 0);
        checkOutput("t6 busy2 drop", busyLow, 112 + FRAME2);

        checkOutput("queue drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
